// File: rtl/led_breathe_pkg.sv
// Shared types and width helpers for the breathing-LED block.
package led_breathe_pkg;

    typedef enum logic [1:0] {
        PhUp     = 2'd0,
        PhHoldHi = 2'd1,
        PhDown   = 2'd2,
        PhHoldLo = 2'd3
    } phase_e;

    function automatic int unsigned duty_max(input int unsigned bits);
        return (1 << bits) - 1;
    endfunction

    function automatic int unsigned gamma_width(input int unsigned bits);
        return 2 * bits;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_breathe_if.sv
// Control/status bundle between the envelope block and its consumer.
interface led_breathe_if #(
    parameter int unsigned PWM_BITS = 8
);
    logic                EN;
    logic                TICK;
    logic                LED;
    logic [PWM_BITS-1:0] DUTY;
    logic [1:0]          PHASE;

    modport master (
        output EN,
        output TICK,
        input  LED,
        input  DUTY,
        input  PHASE
    );

    modport slave (
        input  EN,
        input  TICK,
        output LED,
        output DUTY,
        output PHASE
    );
endinterface

// File: rtl/led_pwm_gen.sv
// PWM generator: free-running counter, period-aligned duty shadow and registered compare.
// LED_BREATHE_GAMMA_EN selects a square-law mapping of the shadowed duty.
module led_pwm_gen
    import led_breathe_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                EN,
    input  logic [PWM_BITS-1:0] DUTY,
    output logic                LED
);

    localparam int unsigned         Max     = duty_max(PWM_BITS);
    localparam logic [PWM_BITS-1:0] LastCnt = PWM_BITS'(Max - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
    logic [PWM_BITS-1:0] duty_mapped;
    logic                led_q, led_d;
    logic                wrap;

`ifdef LED_BREATHE_GAMMA_EN
    localparam int unsigned Gw = gamma_width(PWM_BITS);

    logic [Gw-1:0] duty_ext;
    logic [Gw-1:0] duty_sq;

    // (MAX+1)^2 wraps to 0 in Gw bits, so the -1 still lands on all-ones.
    always_comb begin
        duty_ext    = Gw'(DUTY) + Gw'(1);
        duty_sq     = (duty_ext * duty_ext) - Gw'(1);
        duty_mapped = PWM_BITS'(duty_sq >> PWM_BITS);
    end
`else
    assign duty_mapped = DUTY;
`endif

    always_comb begin
        wrap          = (pwm_cnt_q == LastCnt);
        pwm_cnt_d     = wrap ? '0 : pwm_cnt_q + PWM_BITS'(1);
        duty_active_d = wrap ? duty_mapped : duty_active_q;
        led_d         = EN & (pwm_cnt_q < duty_active_q);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pwm_cnt_q     <= '0;
            duty_active_q <= '0;
            led_q         <= 1'b0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            duty_active_q <= duty_active_d;
            led_q         <= led_d;
        end
    end

    assign LED = led_q;

endmodule

// File: rtl/led_breathe.sv
// Breathing-LED envelope: ramp up, hold, ramp down, hold, driven by upstream TICK strobes.
// Define LED_BREATHE_GAMMA_EN to enable square-law brightness mapping in led_pwm_gen.
module led_breathe
    import led_breathe_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP       = 1,
    parameter int unsigned HOLD_TICKS = 16
) (
    input logic         CLK,
    input logic         RESETN,
    led_breathe_if.slave bus
);

    localparam int unsigned Max = duty_max(PWM_BITS);
    localparam int unsigned Dw  = PWM_BITS + 1;
    localparam int unsigned Hw  = cnt_width(HOLD_TICKS);

    localparam logic [1:0] StUp     = PhUp;
    localparam logic [1:0] StHoldHi = PhHoldHi;
    localparam logic [1:0] StDown   = PhDown;
    localparam logic [1:0] StHoldLo = PhHoldLo;

    localparam logic [PWM_BITS-1:0] DutyMax  = PWM_BITS'(Max);
    localparam logic [Hw-1:0]       HoldLoad = Hw'(HOLD_TICKS - 1);

    logic [1:0]          phase_q, phase_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [Hw-1:0]       hold_q, hold_d;
    logic [Dw-1:0]       up_sum, dn_diff;
    logic [PWM_BITS-1:0] up_sat, dn_sat;

    // Extra top bit catches overflow on the way up and borrow on the way down.
    always_comb begin
        up_sum  = {1'b0, duty_q} + Dw'(STEP);
        dn_diff = {1'b0, duty_q} - Dw'(STEP);
        up_sat  = (up_sum >= Dw'(Max)) ? DutyMax : up_sum[PWM_BITS-1:0];
        dn_sat  = dn_diff[PWM_BITS] ? '0 : dn_diff[PWM_BITS-1:0];
    end

    always_comb begin
        phase_d = phase_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        if (bus.EN && bus.TICK) begin
            unique case (phase_q)
                StUp: begin
                    duty_d = up_sat;
                    if (up_sat == DutyMax) begin
                        phase_d = StHoldHi;
                        hold_d  = HoldLoad;
                    end
                end
                StHoldHi: begin
                    if (hold_q == '0) phase_d = StDown;
                    else              hold_d  = hold_q - Hw'(1);
                end
                StDown: begin
                    duty_d = dn_sat;
                    if (dn_sat == '0) begin
                        phase_d = StHoldLo;
                        hold_d  = HoldLoad;
                    end
                end
                StHoldLo: begin
                    if (hold_q == '0) phase_d = StUp;
                    else              hold_d  = hold_q - Hw'(1);
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            phase_q <= StUp;
            duty_q  <= '0;
            hold_q  <= '0;
        end else begin
            phase_q <= phase_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
        end
    end

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .CLK    (CLK),
        .RESETN (RESETN),
        .EN     (bus.EN),
        .DUTY   (duty_q),
        .LED    (bus.LED)
    );

    assign bus.DUTY  = duty_q;
    assign bus.PHASE = phase_q;

endmodule
